// File: rtl/playback_sequencer_pkg.sv
// rtl/playback_sequencer_pkg.sv - shared state encoding, mode codes and speed limits
package playback_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [1:0] MODE_ONCE = 2'b00;
    localparam logic [1:0] MODE_LOOP = 2'b01;
    localparam logic [1:0] MODE_AB   = 2'b10;

    localparam logic [2:0] SPEED_MAX = 3'd4;
    localparam logic [2:0] SPEED_DEF = 3'd2;

endpackage

// File: rtl/playback_sequencer_if.sv
// rtl/playback_sequencer_if.sv - control pulses in, playback status out
interface playback_sequencer_if #(
    parameter int BEAT_W = 12
);
    logic              play_toggle;
    logic              restart;
    logic              speed_up;
    logic              speed_down;
    logic [1:0]        mode;
    logic              set_a;
    logic              set_b;
    logic [BEAT_W-1:0] ibeat;
    logic              beat_tick;
    logic              playing;
    logic [2:0]        speed;
    logic              done;

    modport master (
        output play_toggle, restart, speed_up, speed_down, mode, set_a, set_b,
        input  ibeat, beat_tick, playing, speed, done
    );

    modport slave (
        input  play_toggle, restart, speed_up, speed_down, mode, set_a, set_b,
        output ibeat, beat_tick, playing, speed, done
    );

endinterface

// File: rtl/playback_sequencer_tempo_tick.sv
// rtl/playback_sequencer_tempo_tick.sv - programmable beat divider with hold and clear
module tempo_tick #(
    parameter int DIV_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);

    logic [DIV_W-1:0] count_q;

    assign tick = en && (count_q == period - DIV_W'(1));

    // Count holds whenever en is low, so a pause resumes from the same phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clr || tick) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/playback_sequencer.sv
// rtl/playback_sequencer.sv - beat sequencer with play/pause, tempo levels and once/loop/A-B modes
module playback_sequencer
    import playback_sequencer_pkg::*;
#(
    parameter int LEN      = 64,
    parameter int BEAT_W   = 12,
    parameter int BASE_DIV = 12_500_000,
    parameter int DIV_W    = 27
) (
    input logic                 clk,
    input logic                 rst,
    playback_sequencer_if.slave bus
);

    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(LEN - 1);
    localparam logic [DIV_W-1:0]  FULL_PERIOD = DIV_W'(4 * BASE_DIV);

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] ibeat_q, ibeat_d;
    logic [BEAT_W-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]        speed_q, speed_d;
    logic              beat_tick_q, beat_tick_d;
    logic              done_q, done_d;
    logic              playing_q;
    logic              cnt_clr;
    logic              tick_raw;
    logic              at_end;
    logic [BEAT_W-1:0] adv;
    logic [DIV_W-1:0]  period;

    assign period = FULL_PERIOD >> speed_q;

    tempo_tick #(
        .DIV_W (DIV_W)
    ) u_tempo_tick (
        .clk    (clk),
        .rst    (rst),
        .en     (state_q == ST_PLAY),
        .clr    (cnt_clr),
        .period (period),
        .tick   (tick_raw)
    );

    always_comb begin
        state_d     = state_q;
        ibeat_d     = ibeat_q;
        speed_d     = speed_q;
        a_d         = a_q;
        b_d         = b_q;
        beat_tick_d = 1'b0;
        done_d      = 1'b0;
        cnt_clr     = 1'b0;
        at_end      = (ibeat_q == LAST_BEAT);
        adv         = at_end ? '0 : ibeat_q + BEAT_W'(1);

        // A degenerate A-B window (A >= B) falls through to plain looping.
        if (bus.mode == MODE_AB && a_q < b_q && (ibeat_q == b_q || at_end)) begin
            adv = a_q;
        end

        if (bus.restart) begin
            ibeat_d = '0;
            cnt_clr = 1'b1;
            if (state_q == ST_DONE) begin
                state_d = ST_IDLE;
            end
        end else if (tick_raw) begin
            beat_tick_d = 1'b1;
            if (bus.mode == MODE_ONCE && at_end) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end else begin
                ibeat_d = adv;
            end
        end else if (bus.play_toggle) begin
            unique case (state_q)
                ST_IDLE:  state_d = ST_PLAY;
                ST_PLAY:  state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_PLAY;
                ST_DONE: begin
                    state_d = ST_PLAY;
                    ibeat_d = '0;
                    cnt_clr = 1'b1;
                end
                default:  state_d = ST_IDLE;
            endcase
        end

        if (bus.speed_up && !bus.speed_down && speed_q != SPEED_MAX) begin
            speed_d = speed_q + 3'd1;
            cnt_clr = 1'b1;
        end else if (bus.speed_down && !bus.speed_up && speed_q != 3'd0) begin
            speed_d = speed_q - 3'd1;
            cnt_clr = 1'b1;
        end

        if (bus.set_a) a_d = ibeat_q;
        if (bus.set_b) b_d = ibeat_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ibeat_q     <= '0;
            speed_q     <= SPEED_DEF;
            a_q         <= '0;
            b_q         <= LAST_BEAT;
            beat_tick_q <= 1'b0;
            done_q      <= 1'b0;
            playing_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ibeat_q     <= ibeat_d;
            speed_q     <= speed_d;
            a_q         <= a_d;
            b_q         <= b_d;
            beat_tick_q <= beat_tick_d;
            done_q      <= done_d;
            playing_q   <= (state_d == ST_PLAY);
        end
    end

    assign bus.ibeat     = ibeat_q;
    assign bus.beat_tick = beat_tick_q;
    assign bus.playing   = playing_q;
    assign bus.speed     = speed_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_playback_sequencer.sv
// tb/tb_playback_sequencer.sv - scoreboard bench with directed scenarios and random pulses
module tb_playback_sequencer;

    localparam int LEN      = 8;
    localparam int BEAT_W   = 4;
    localparam int BASE_DIV = 4;
    localparam int DIV_W    = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    playback_sequencer_if #(.BEAT_W(BEAT_W)) bus ();

    playback_sequencer #(
        .LEN      (LEN),
        .BEAT_W   (BEAT_W),
        .BASE_DIV (BASE_DIV),
        .DIV_W    (DIV_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef enum {STOPPED, RUNNING, HELD, FINISHED} mst_t;
    typedef struct {
        int cyc;
        int beat;
        bit tick;
        bit play;
        int spd;
        bit done;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    mst_t m_st;
    int   m_beat, m_cnt, m_spd, m_a, m_b;
    int   cur_mode = 1;
    bit   cur_rstn = 1'b0;

    function automatic void chk(string name, int act, int want);
        n_vec++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, want, $time);
        end
    endfunction

    function automatic void model_reset();
        m_st = STOPPED; m_beat = 0; m_cnt = 0; m_spd = 2; m_a = 0; m_b = LEN - 1;
    endfunction

    function automatic int next_beat(int mode);
        if (mode == 2 && m_a < m_b && (m_beat == m_b || m_beat == LEN - 1)) return m_a;
        return (m_beat + 1) % LEN;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares DUT outputs after each edge with the entry queued for that edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            e = sb_q.pop_front();
            chk("sb_ibeat", int'(bus.ibeat), e.beat);
            chk("sb_beat_tick", int'(bus.beat_tick), int'(e.tick));
            chk("sb_playing", int'(bus.playing), int'(e.play));
            chk("sb_speed", int'(bus.speed), e.spd);
            chk("sb_done", int'(bus.done), int'(e.done));
        end
    end

    task automatic step(input bit tg = 0, input bit rs = 0, input bit up = 0,
                        input bit dn = 0, input bit sa = 0, input bit sb = 0);
        exp_t e;
        int   period, old_beat;
        bit   tk;
        rst             = cur_rstn;
        bus.play_toggle = tg;
        bus.restart     = rs;
        bus.speed_up    = up;
        bus.speed_down  = dn;
        bus.set_a       = sa;
        bus.set_b       = sb;
        bus.mode        = 2'(cur_mode);
        tk     = 1'b0;
        e.done = 1'b0;
        if (!cur_rstn) begin
            model_reset();
        end else begin
            period   = (4 * BASE_DIV) >> m_spd;
            old_beat = m_beat;
            tk       = (m_st == RUNNING) && (m_cnt == period - 1) && !rs;
            if (rs) begin
                m_beat = 0; m_cnt = 0;
                if (m_st == FINISHED) m_st = STOPPED;
            end else if (tk) begin
                m_cnt = 0;
                if (cur_mode == 0 && m_beat == LEN - 1) begin
                    m_st = FINISHED; e.done = 1'b1;
                end else begin
                    m_beat = next_beat(cur_mode);
                end
            end else begin
                if (m_st == RUNNING) m_cnt++;
                if (tg) begin
                    case (m_st)
                        STOPPED:  m_st = RUNNING;
                        RUNNING:  m_st = HELD;
                        HELD:     m_st = RUNNING;
                        FINISHED: begin m_st = RUNNING; m_beat = 0; end
                    endcase
                end
            end
            if (up && !dn && m_spd < 4) begin m_spd++; m_cnt = 0; end
            else if (dn && !up && m_spd > 0) begin m_spd--; m_cnt = 0; end
            if (sa) m_a = old_beat;
            if (sb) m_b = old_beat;
        end
        e.cyc  = cyc + 1;
        e.beat = m_beat;
        e.tick = tk;
        e.play = (m_st == RUNNING);
        e.spd  = m_spd;
        sb_q.push_back(e);
        @(posedge clk);
        #2;
        {bus.play_toggle, bus.restart, bus.speed_up, bus.speed_down, bus.set_a, bus.set_b} = '0;
    endtask

    task automatic wait_tick(input int beat, input string name);
        int g = 0;
        while (!(bus.beat_tick && (beat < 0 || int'(bus.ibeat) == beat)) && g < 200) begin
            step(); g++;
        end
        chk(name, int'(g < 200), 1);
    endtask

    task automatic measure(output int p);
        wait_tick(-1, "meas_sync");
        p = 0;
        do begin step(); p++; end while (!bus.beat_tick && p < 64);
    endtask

    initial begin
        int n, p, b0, g;
        int seq[$];
        {bus.play_toggle, bus.restart, bus.speed_up, bus.speed_down, bus.set_a, bus.set_b} = '0;
        bus.mode = 2'b01;
        model_reset();
        @(posedge clk); #2;

        repeat (3) step();
        chk("rst_ibeat", int'(bus.ibeat), 0);
        chk("rst_speed", int'(bus.speed), 2);
        chk("rst_playing", int'(bus.playing), 0);
        cur_rstn = 1'b1;
        step();

        // Loop mode: ten beats in forty cycles at period 4.
        cur_mode = 1;
        step(.tg(1));
        chk("loop_playing", int'(bus.playing), 1);
        n = 0;
        repeat (40) begin step(); if (bus.beat_tick) n++; end
        chk("loop_ticks", n, 10);
        chk("loop_ibeat", int'(bus.ibeat), 2);

        // Once mode ends on the last beat.
        cur_mode = 0;
        step(.rs(1));
        n = 0;
        repeat (32) begin step(); if (bus.done) n++; end
        repeat (5) begin step(); if (bus.done) n++; end
        chk("once_done_count", n, 1);
        chk("once_ibeat", int'(bus.ibeat), 7);
        chk("once_playing", int'(bus.playing), 0);
        step(.tg(1));
        chk("done_resume_ibeat", int'(bus.ibeat), 0);
        chk("done_resume_playing", int'(bus.playing), 1);

        // A-B window 2..5.
        cur_mode = 2;
        g = 0;
        while (int'(bus.ibeat) != 2 && g < 200) begin step(); g++; end
        step(.sa(1));
        while (int'(bus.ibeat) != 5 && g < 400) begin step(); g++; end
        chk("ab_reach", int'(g < 400), 1);
        step(.sb(1));
        g = 0;
        while (seq.size() < 5 && g < 200) begin
            step(); g++;
            if (bus.beat_tick) seq.push_back(int'(bus.ibeat));
        end
        chk("ab_seq_len", seq.size(), 5);
        if (seq.size() == 5) begin
            chk("ab_seq0", seq[0], 2);
            chk("ab_seq1", seq[1], 3);
            chk("ab_seq2", seq[2], 4);
            chk("ab_seq3", seq[3], 5);
            chk("ab_seq4", seq[4], 2);
        end

        // Speed levels and saturation.
        cur_mode = 1;
        repeat (3) step(.up(1));
        chk("speed_max", int'(bus.speed), 4);
        measure(p);
        chk("period_fast", p, 1);
        repeat (6) step(.dn(1));
        chk("speed_min", int'(bus.speed), 0);
        measure(p);
        chk("period_slow", p, 16);
        step(.up(1), .dn(1));
        chk("speed_both", int'(bus.speed), 0);
        repeat (2) step(.up(1));
        chk("speed_restored", int'(bus.speed), 2);

        // Pause freezes the divider phase at count 2.
        wait_tick(-1, "pause_sync");
        step();
        step(.tg(1));
        chk("pause_playing", int'(bus.playing), 0);
        b0 = int'(bus.ibeat);
        n = 0;
        repeat (20) begin step(); if (bus.beat_tick) n++; end
        chk("pause_no_tick", n, 0);
        chk("pause_ibeat", int'(bus.ibeat), b0);
        step(.tg(1));
        chk("resume_playing", int'(bus.playing), 1);
        step();
        chk("resume_tick1", int'(bus.beat_tick), 0);
        step();
        chk("resume_tick2", int'(bus.beat_tick), 1);

        // Restart colliding with the tick into beat 3.
        wait_tick(2, "rs_sync");
        repeat (3) step();
        step(.rs(1));
        chk("rs_ibeat", int'(bus.ibeat), 0);
        chk("rs_no_tick", int'(bus.beat_tick), 0);
        chk("rs_playing", int'(bus.playing), 1);

        // Asynchronous reset mid-play.
        step(.up(1));
        repeat (5) step();
        #2;
        rst = 1'b0;
        cur_rstn = 1'b0;
        #1;
        chk("arst_ibeat", int'(bus.ibeat), 0);
        chk("arst_playing", int'(bus.playing), 0);
        chk("arst_speed", int'(bus.speed), 2);
        chk("arst_tick", int'(bus.beat_tick), 0);
        chk("arst_done", int'(bus.done), 0);
        step();
        step();
        cur_rstn = 1'b1;
        step();
        chk("arst_idle", int'(bus.playing), 0);
        step(.tg(1));
        chk("arst_replay", int'(bus.playing), 1);

        // Random pulses against the model.
        repeat (1500) begin
            if ($urandom_range(0, 31) == 0) cur_mode = int'($urandom_range(0, 3));
            cur_rstn = ($urandom_range(0, 299) != 0);
            step(.tg($urandom_range(0, 11) == 0), .rs($urandom_range(0, 63) == 0),
                 .up($urandom_range(0, 24) == 0), .dn($urandom_range(0, 24) == 0),
                 .sa($urandom_range(0, 15) == 0), .sb($urandom_range(0, 15) == 0));
        end
        cur_rstn = 1'b1;
        step();
        step();
        chk("sb_drain", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
